// File: rtl/llama_layer_mul_arb.sv
// llama_layer_mul_arb
//   Round-robin arbiter that lets NUM_REQ requesters share one external
//   combinational multiplier. The block registers the product in a single
//   output stage and tags it with the index of the requester that owns it.
//
// Ports
//   ap_clk, ap_rst_n        clock, synchronous active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b            packed operands, requester i at [i*W +: W]
//   mul_din0/1, mul_dout    operands to and product from the shared multiplier
//   rsp_valid/rsp_ready     result handshake
//   rsp_data, rsp_id        registered product and the owning requester index
module llama_layer_mul_arb #(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = 10,
    parameter int B_WIDTH = 36,
    parameter int P_WIDTH = 36,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic [A_WIDTH-1:0]         mul_din0,
    output logic [B_WIDTH-1:0]         mul_din1,
    input  logic [P_WIDTH-1:0]         mul_dout,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [P_WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]            rsp_id
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [P_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [A_WIDTH-1:0] din0_q, din0_d;
    logic [B_WIDTH-1:0] din1_q, din1_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic               can_accept;
    logic               transfer;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // The output register can take a new result when empty, or when the
    // current one drains in this same cycle.
    assign can_accept = (state_q == EMPTY) || rsp_ready;
    assign transfer   = |(req_valid & req_ready);

    // Process 1: state register and datapath registers.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q      <= EMPTY;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            din0_q       <= '0;
            din1_q       <= '0;
        end else begin
            state_q      <= state_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
            din0_q       <= din0_d;
            din1_q       <= din1_d;
        end
    end

    // Process 2: next-state logic.
    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        din0_d       = din0_q;
        din1_d       = din1_q;

        // Remember the last driven operands so the multiplier inputs stay
        // quiet while no one is requesting.
        if (grant_found) begin
            din0_d = mul_din0;
            din1_d = mul_din1;
        end

        case (state_q)
            EMPTY: begin
                if (transfer) state_d = FULL;
            end
            FULL: begin
                if (rsp_ready && !transfer) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase

        if (transfer) begin
            rsp_data_d   = mul_dout;
            rsp_id_d     = grant_idx;
            last_grant_d = grant_idx;
        end
    end

    // Process 3: outputs.
    always_comb begin
        req_ready = '0;
        mul_din0  = din0_q;
        mul_din1  = din1_q;
        if (grant_found) begin
            mul_din0 = req_a[grant_idx*A_WIDTH +: A_WIDTH];
            mul_din1 = req_b[grant_idx*B_WIDTH +: B_WIDTH];
            if (ap_rst_n && can_accept) req_ready[grant_idx] = 1'b1;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: doc/llama_layer_mul_arb.md
LLAMA_LAYER_MUL_ARB -- requirements
Module: llama_layer_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier.
REQ-002 SHALL have parameter A_WIDTH, default 10, signed operand A width.
REQ-003 SHALL have parameter B_WIDTH, default 36, signed operand B width.
REQ-004 SHALL have parameter P_WIDTH, default 36, product width; product is the low P_WIDTH bits of the signed product.
REQ-005 SHALL have port ap_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port ap_rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester operand valid.
REQ-008 SHALL have port req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 SHALL have port req_a  in  NUM_REQ*A_WIDTH  packed A operands; requester i at bits [i*A_WIDTH +: A_WIDTH].
REQ-010 SHALL have port req_b  in  NUM_REQ*B_WIDTH  packed B operands, packed the same way.
REQ-011 SHALL have port mul_din0  out  A_WIDTH  A operand to the shared combinational multiplier.
REQ-012 SHALL have port mul_din1  out  B_WIDTH  B operand to the shared combinational multiplier.
REQ-013 SHALL have port mul_dout  in  P_WIDTH  product returned by the multiplier in the same cycle.
REQ-014 SHALL have port rsp_valid  out  1  result valid.
REQ-015 SHALL have port rsp_ready  in  1  downstream accept.
REQ-016 SHALL have port rsp_data  out  P_WIDTH  registered product.
REQ-017 SHALL have port rsp_id  out  clog2(NUM_REQ)  index of the requester that owns rsp_data.

Function
REQ-018 SHALL implement a two-state FSM over the output register: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-019 SHALL define can_accept = EMPTY, or FULL with rsp_ready=1 in the same cycle.
REQ-020 SHALL select the grant combinationally by round-robin: search starts at last_grant+1 modulo NUM_REQ, and the first i with req_valid[i]=1 wins.
REQ-021 SHALL drive req_ready[grant]=1 only when can_accept=1 and some req_valid is 1; all other req_ready bits SHALL be 0.
REQ-022 SHALL drive mul_din0 and mul_din1 from the granted requester's operands whenever a grant exists, and hold their last values otherwise (no toggling while idle).
REQ-023 SHALL perform a transfer when req_valid[i]=1 and req_ready[i]=1; at the next edge it SHALL load rsp_data<=mul_dout, rsp_id<=i, rsp_valid<=1 and last_grant<=i.
REQ-024 SHALL have latency of exactly 1 cycle from transfer to rsp_valid, and throughput of one result per cycle while rsp_ready=1.
REQ-025 SHALL go FULL->EMPTY when rsp_ready=1 and no transfer occurs in that cycle.
REQ-026 SHALL go FULL->FULL when a drain and a transfer occur in the same cycle; the register then loads the new result with no bubble.
REQ-027 SHALL, while FULL with rsp_ready=0, hold rsp_data, rsp_id and rsp_valid stable, drive all req_ready to 0, and leave last_grant unchanged.
REQ-028 SHALL never update last_grant without a transfer; a requester that drops req_valid before being granted forfeits nothing.
REQ-029 SHALL take the product's width and sign from the multiplier only; the block performs no arithmetic on data.

Reset
REQ-030 SHALL, with ap_rst_n=0 at a rising edge, set rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=NUM_REQ-1 (requester 0 has first priority), state EMPTY.
REQ-031 SHALL force req_ready=0 in every cycle where ap_rst_n=0.
REQ-032 SHALL discard any result held when reset is asserted mid-operation; no response is issued for it.

Verification
REQ-033 SHALL cover: only req0 valid with a=10'h3FD (-3), b=5, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=36'hFFFFFFFF1 (-15), rsp_id=0.
REQ-034 SHALL cover: all four requesters held valid, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, rsp_valid continuously 1.
REQ-035 SHALL cover: rsp_ready=0 for 3 cycles while FULL -> rsp_data and rsp_id stable, req_ready=0; after release the next grant follows the round-robin order.
REQ-036 SHALL cover: a=511, b=2^35-1 -> rsp_data=36'h7FFFFFE01 (wrapped low 36 bits).
REQ-037 SHALL cover: ap_rst_n=0 for one cycle while FULL with rsp_id=2 -> rsp_valid=0 next cycle, and with all valid the next grant is 0.
REQ-038 SHALL cover: req1 and req3 valid, last_grant=1 -> grant 3, then 1.
